// File: rtl/glb_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : glb_stream_pkg
//  Description : Shared constants, state encoding and configuration bundle
//                for the GLB <-> PRR stream engines.
//  Revision    : 1.0  initial release
// ============================================================================
package glb_stream_pkg;

    localparam int C_LOOP_LEVEL      = 8;
    localparam int C_ADDR_WIDTH      = 19;
    localparam int C_MEM_DATA_WIDTH  = 64;
    localparam int C_EXTENT_WIDTH    = 16;
    localparam int C_CYCLE_CNT_WIDTH = 16;
    localparam int C_DIM_WIDTH       = $clog2(C_LOOP_LEVEL + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stream_state_t;

    typedef struct packed {
        logic [C_ADDR_WIDTH-1:0]                         start_addr;
        logic [C_DIM_WIDTH-1:0]                          dim;
        logic [C_LOOP_LEVEL-1:0][C_EXTENT_WIDTH-1:0]     extent;
        logic [C_LOOP_LEVEL-1:0][C_ADDR_WIDTH-1:0]       data_stride;
        logic [C_LOOP_LEVEL-1:0][C_CYCLE_CNT_WIDTH-1:0]  cycle_stride;
    } stream_cfg_t;

endpackage
`default_nettype wire

// File: rtl/glb_loop_iter.sv
`default_nettype none
// ============================================================================
//  Module      : glb_loop_iter
//  Description : Loop-nest odometer. Holds the iteration vector and, per
//                level, the issue-cycle / address offset at which that level's
//                current iteration began. Advancing level k adds its stride to
//                level k's base and copies the result into all lower levels,
//                so no multipliers are needed.
//  Revision    : 1.0  initial release
//  Ports       : clk, reset (async, active-high)
//                clear  - zero iteration vector and accumulators
//                step   - advance one iteration (level 0 fastest)
//                dim, extent, data_stride, cycle_stride, start_addr - config
//                t      - issue cycle target of current iteration
//                a      - byte address of current iteration
//                last   - current iteration is the final one
// ============================================================================
module glb_loop_iter #(
    parameter int LOOP_LEVEL      = 8,
    parameter int ADDR_WIDTH      = 19,
    parameter int EXTENT_WIDTH    = 16,
    parameter int CYCLE_CNT_WIDTH = 16,
    parameter int DIM_WIDTH       = $clog2(LOOP_LEVEL + 1)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       clear,
    input  logic                                       step,
    input  logic [DIM_WIDTH-1:0]                       dim,
    input  logic [LOOP_LEVEL-1:0][EXTENT_WIDTH-1:0]    extent,
    input  logic [LOOP_LEVEL-1:0][ADDR_WIDTH-1:0]      data_stride,
    input  logic [LOOP_LEVEL-1:0][CYCLE_CNT_WIDTH-1:0] cycle_stride,
    input  logic [ADDR_WIDTH-1:0]                      start_addr,
    output logic [CYCLE_CNT_WIDTH-1:0]                 t,
    output logic [ADDR_WIDTH-1:0]                      a,
    output logic                                       last
);

    logic [LOOP_LEVEL-1:0][EXTENT_WIDTH-1:0]    r_idx;
    logic [LOOP_LEVEL-1:0][ADDR_WIDTH-1:0]      r_base_a;
    logic [LOOP_LEVEL-1:0][CYCLE_CNT_WIDTH-1:0] r_base_t;

    logic [LOOP_LEVEL-1:0]      w_inc;
    logic [LOOP_LEVEL-1:0]      w_wrap;
    logic [ADDR_WIDTH-1:0]      w_new_a;
    logic [CYCLE_CNT_WIDTH-1:0] w_new_t;
    logic [EXTENT_WIDTH-1:0]    w_ext_m1;
    logic                       w_at_max;
    logic                       w_carry;

    // Ripple a carry from level 0 upward. Inactive levels (k >= dim) always
    // look saturated so the carry passes through them; an extent of 0 is
    // treated as 1 by clamping extent-1 to 0.
    always_comb begin
        w_inc    = '0;
        w_wrap   = '0;
        w_new_a  = '0;
        w_new_t  = '0;
        w_ext_m1 = '0;
        w_at_max = 1'b0;
        w_carry  = 1'b1;
        for (int k = 0; k < LOOP_LEVEL; k++) begin
            w_ext_m1 = (extent[k] == '0) ? '0 : extent[k] - 1'b1;
            w_at_max = (k >= int'(dim)) || (r_idx[k] == w_ext_m1);
            if (w_carry) begin
                if (w_at_max) begin
                    w_wrap[k] = 1'b1;
                end else begin
                    w_inc[k] = 1'b1;
                    w_new_a  = r_base_a[k] + data_stride[k];
                    w_new_t  = r_base_t[k] + cycle_stride[k];
                end
            end
            w_carry = w_carry & w_at_max;
        end
        last = w_carry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_base_a <= '0;
            r_base_t <= '0;
        end else if (clear) begin
            r_idx    <= '0;
            r_base_a <= '0;
            r_base_t <= '0;
        end else if (step) begin
            for (int k = 0; k < LOOP_LEVEL; k++) begin
                if (w_inc[k]) begin
                    r_idx[k]    <= r_idx[k] + 1'b1;
                    r_base_a[k] <= w_new_a;
                    r_base_t[k] <= w_new_t;
                end else if (w_wrap[k]) begin
                    r_idx[k]    <= '0;
                    r_base_a[k] <= w_new_a;
                    r_base_t[k] <= w_new_t;
                end
            end
        end
    end

    assign t = r_base_t[0];
    assign a = start_addr + r_base_a[0];

endmodule
`default_nettype wire

// File: rtl/glb_g2prr_stream.sv
`default_nettype none
// ============================================================================
//  Module      : glb_g2prr_stream
//  Description : GLB-side load streamer for one PRR. Walks a loop nest, issues
//                bank reads at programmed cycle offsets and emits 16-bit words
//                with a valid strobe on io1_g2io / io16_g2io.
//  Revision    : 1.0  initial release
//  Macro       : GLB_G2PRR_STREAM_PERF_EN adds perf_word_cnt / perf_stall_cnt
//  Ports       : clk, reset (async, active-high)
//                start, flush, stall          - control
//                cfg_*                        - stream configuration
//                mem_rd_en/addr, mem_rd_data  - GLB bank read port
//                io1_g2io, io16_g2io          - registered stream to PRR
//                busy, done                   - status
// ============================================================================
module glb_g2prr_stream
    import glb_stream_pkg::*;
#(
    parameter int LOOP_LEVEL      = C_LOOP_LEVEL,
    parameter int ADDR_WIDTH      = C_ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH  = C_MEM_DATA_WIDTH,
    parameter int RD_LATENCY      = 2,
    parameter int EXTENT_WIDTH    = C_EXTENT_WIDTH,
    parameter int CYCLE_CNT_WIDTH = C_CYCLE_CNT_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic                                       flush,
    input  logic                                       stall,
    input  logic [ADDR_WIDTH-1:0]                      cfg_start_addr,
    input  logic [$clog2(LOOP_LEVEL+1)-1:0]            cfg_dim,
    input  logic [LOOP_LEVEL-1:0][EXTENT_WIDTH-1:0]    cfg_extent,
    input  logic [LOOP_LEVEL-1:0][ADDR_WIDTH-1:0]      cfg_data_stride,
    input  logic [LOOP_LEVEL-1:0][CYCLE_CNT_WIDTH-1:0] cfg_cycle_stride,
    output logic                                       mem_rd_en,
    output logic [ADDR_WIDTH-4:0]                      mem_rd_addr,
    input  logic [MEM_DATA_WIDTH-1:0]                  mem_rd_data,
    output logic                                       io1_g2io,
    output logic [15:0]                                io16_g2io,
    output logic                                       busy,
    output logic                                       done
`ifdef GLB_G2PRR_STREAM_PERF_EN
    ,
    output logic [31:0]                                perf_word_cnt,
    output logic [31:0]                                perf_stall_cnt
`endif
);

    stream_state_t                 r_state;
    stream_state_t                 w_state_nxt;
    stream_cfg_t                   r_cfg;
    logic [CYCLE_CNT_WIDTH-1:0]    r_cyc;
    logic [RD_LATENCY-1:0]         r_pipe_vld;
    logic [RD_LATENCY-1:0][1:0]    r_pipe_lane;
    logic [RD_LATENCY-1:0]         w_pipe_rest;
    logic                          r_io1;
    logic [15:0]                   r_io16;
    logic                          r_done;

    logic [CYCLE_CNT_WIDTH-1:0]    w_t;
    logic [ADDR_WIDTH-1:0]         w_a;
    logic                          w_last;
    logic                          w_start_go;
    logic                          w_issue;
    logic                          w_emit;
    logic                          w_last_emit;
    logic                          w_unused_addr_lsb;

    assign w_start_go = start && (r_state == IDLE) && !flush;
    assign w_issue    = (r_state == RUN) && !stall && !flush && (r_cyc >= w_t);
    assign w_emit     = r_pipe_vld[RD_LATENCY-1] && !flush;

    // Pipe contents below the output tap; empty means the word now leaving
    // the pipe is the final one of the stream.
    assign w_pipe_rest = r_pipe_vld << 1;
    assign w_last_emit = (r_state == DRAIN) && r_pipe_vld[RD_LATENCY-1] &&
                         (w_pipe_rest == '0);

    glb_loop_iter #(
        .LOOP_LEVEL      (LOOP_LEVEL),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .EXTENT_WIDTH    (EXTENT_WIDTH),
        .CYCLE_CNT_WIDTH (CYCLE_CNT_WIDTH),
        .DIM_WIDTH       ($clog2(LOOP_LEVEL+1))
    ) u_iter (
        .clk          (clk),
        .reset        (reset),
        .clear        (w_start_go),
        .step         (w_issue),
        .dim          (r_cfg.dim),
        .extent       (r_cfg.extent),
        .data_stride  (r_cfg.data_stride),
        .cycle_stride (r_cfg.cycle_stride),
        .start_addr   (r_cfg.start_addr),
        .t            (w_t),
        .a            (w_a),
        .last         (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_go && (cfg_dim != '0)) w_state_nxt = RUN;
            RUN:     if (w_issue && w_last)             w_state_nxt = DRAIN;
            DRAIN:   if (w_last_emit)                   w_state_nxt = IDLE;
            default:                                    w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
        end
    end

    // Config capture and the free-running (non-wrapping) issue-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg <= '0;
            r_cyc <= '0;
        end else if (w_start_go) begin
            r_cfg.start_addr   <= cfg_start_addr;
            r_cfg.dim          <= cfg_dim;
            r_cfg.extent       <= cfg_extent;
            r_cfg.data_stride  <= cfg_data_stride;
            r_cfg.cycle_stride <= cfg_cycle_stride;
            r_cyc              <= '0;
        end else if ((r_state == RUN) && !stall && !flush && (r_cyc != '1)) begin
            r_cyc <= r_cyc + 1'b1;
        end
    end

    // Lane pipe tracks each read's lane select for the fixed bank latency.
    // It keeps shifting under stall because returned data cannot be held off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipe_vld  <= '0;
            r_pipe_lane <= '0;
            r_io1       <= 1'b0;
            r_io16      <= '0;
            r_done      <= 1'b0;
        end else if (flush) begin
            r_pipe_vld  <= '0;
            r_pipe_lane <= '0;
            r_io1       <= 1'b0;
            r_io16      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_pipe_vld  <= RD_LATENCY'({r_pipe_vld, w_issue});
            r_pipe_lane <= (2*RD_LATENCY)'({r_pipe_lane, (w_issue ? w_a[2:1] : 2'b00)});
            r_io1       <= w_emit;
            r_io16      <= w_emit ? mem_rd_data[16*r_pipe_lane[RD_LATENCY-1] +: 16] : 16'h0;
            r_done      <= w_last_emit || (w_start_go && (cfg_dim == '0));
        end
    end

    assign mem_rd_en         = w_issue;
    assign mem_rd_addr       = w_issue ? w_a[ADDR_WIDTH-1:3] : '0;
    assign io1_g2io          = r_io1;
    assign io16_g2io         = r_io16;
    assign busy              = (r_state == RUN) || (r_state == DRAIN);
    assign done              = r_done;
    assign w_unused_addr_lsb = w_a[0];

`ifdef GLB_G2PRR_STREAM_PERF_EN
    logic [31:0] r_perf_word_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_word_cnt  <= '0;
            r_perf_stall_cnt <= '0;
        end else if (w_start_go) begin
            r_perf_word_cnt  <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_emit && (r_perf_word_cnt != '1)) begin
                r_perf_word_cnt <= r_perf_word_cnt + 1'b1;
            end
            if ((r_state == RUN) && stall && (r_perf_stall_cnt != '1)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 1'b1;
            end
        end
    end

    assign perf_word_cnt  = r_perf_word_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_glb_g2prr_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_glb_g2prr_stream
//  Description : Directed self-checking bench for glb_g2prr_stream. A bank
//                model returns word n as four lanes {n[11:0], lane[3:0]} with
//                a fixed two-cycle latency; a monitor logs issues, valids and
//                done pulses by cycle number for each scenario task.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_glb_g2prr_stream;

    localparam int LL  = 8;
    localparam int AW  = 19;
    localparam int MDW = 64;
    localparam int RL  = 2;
    localparam int EW  = 16;
    localparam int CW  = 16;
    localparam logic [63:0] JUNK = 64'hBAD0_BAD1_BAD2_BAD3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   flush;
    logic                   stall;
    logic [AW-1:0]          cfg_start_addr;
    logic [3:0]             cfg_dim;
    logic [LL-1:0][EW-1:0]  cfg_extent;
    logic [LL-1:0][AW-1:0]  cfg_data_stride;
    logic [LL-1:0][CW-1:0]  cfg_cycle_stride;
    logic                   mem_rd_en;
    logic [AW-4:0]          mem_rd_addr;
    logic [MDW-1:0]         mem_rd_data = '0;
    logic                   io1_g2io;
    logic [15:0]            io16_g2io;
    logic                   busy;
    logic                   done;
`ifdef GLB_G2PRR_STREAM_PERF_EN
    logic [31:0]            perf_word_cnt;
    logic [31:0]            perf_stall_cnt;
`endif

    glb_g2prr_stream #(
        .LOOP_LEVEL(LL), .ADDR_WIDTH(AW), .MEM_DATA_WIDTH(MDW),
        .RD_LATENCY(RL), .EXTENT_WIDTH(EW), .CYCLE_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .stall(stall),
        .cfg_start_addr(cfg_start_addr), .cfg_dim(cfg_dim), .cfg_extent(cfg_extent),
        .cfg_data_stride(cfg_data_stride), .cfg_cycle_stride(cfg_cycle_stride),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .io1_g2io(io1_g2io), .io16_g2io(io16_g2io), .busy(busy), .done(done)
`ifdef GLB_G2PRR_STREAM_PERF_EN
        , .perf_word_cnt(perf_word_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int checks = 0;
    int errors = 0;
    int iss_cyc[$];
    int iss_addr[$];
    int vld_cyc[$];
    int vld_data[$];
    int done_cyc[$];
    int idle_bad = 0;
    logic [63:0] p1 = JUNK;
    logic [63:0] p2 = JUNK;

    function automatic logic [63:0] mem_word(input logic [15:0] n);
        logic [63:0] w;
        w = '0;
        for (int l = 0; l < 4; l++) w[16*l +: 16] = {n[11:0], 4'(l)};
        return w;
    endfunction

    // Monitor and fixed-latency bank model, both sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_rd_en === 1'b1) begin
            iss_cyc.push_back(cyc_n);
            iss_addr.push_back(int'(mem_rd_addr));
        end
        if (io1_g2io === 1'b1) begin
            vld_cyc.push_back(cyc_n);
            vld_data.push_back(int'(io16_g2io));
        end else if (io16_g2io !== 16'h0) begin
            idle_bad++;
        end
        if (done === 1'b1) done_cyc.push_back(cyc_n);
        mem_rd_data = p2;
        p2 = p1;
        p1 = (mem_rd_en === 1'b1) ? mem_word(mem_rd_addr) : JUNK;
    end

    task automatic clear_logs();
        iss_cyc.delete(); iss_addr.delete();
        vld_cyc.delete(); vld_data.delete(); done_cyc.delete();
    endtask

    task automatic cfg_1d(input logic [AW-1:0] sa, input int ext, input int ds, input int cs);
        cfg_start_addr   = sa;
        cfg_dim          = 4'd1;
        cfg_extent       = '0;
        cfg_data_stride  = '0;
        cfg_cycle_stride = '0;
        cfg_extent[0]       = EW'(ext);
        cfg_data_stride[0]  = AW'(ds);
        cfg_cycle_stride[0] = CW'(cs);
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk); #1;
        start = 1'b1;
        s = cyc_n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; stall = 1'b0;
        cfg_1d('0, 0, 0, 0);
        cfg_dim = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({io1_g2io, io16_g2io, mem_rd_en, mem_rd_addr, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: io1=%b io16=%h en=%b addr=%h busy=%b done=%b exp all 0",
                     io1_g2io, io16_g2io, mem_rd_en, mem_rd_addr, busy, done);
        end
        reset = 1'b0;
        run_cycles(2);
    endtask

    task automatic test_1d();
        int s;
        int e_iss[4] = '{1, 2, 3, 4};
        int e_vld[4] = '{4, 5, 6, 7};
        int e_dat[4] = '{32'h20, 32'h21, 32'h22, 32'h23};
        clear_logs();
        cfg_1d(19'h10, 4, 2, 1);
        pulse_start(s);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL 1d_busy: got %b exp 1", busy); end
        // later config changes must not disturb the running stream
        cfg_start_addr = 19'h400; cfg_dim = 4'd3; cfg_extent[0] = 16'd7; cfg_data_stride[0] = 19'd100;
        run_cycles(15);
        checks++;
        if (iss_cyc.size() != 4 || vld_cyc.size() != 4) begin
            errors++;
            $display("FAIL 1d_count: issues %0d valids %0d exp 4 4", iss_cyc.size(), vld_cyc.size());
        end
        for (int i = 0; i < 4 && i < iss_cyc.size(); i++) begin
            checks++;
            if (iss_cyc[i] != s + e_iss[i] || iss_addr[i] != 2) begin
                errors++;
                $display("FAIL 1d_issue[%0d]: cyc %0d addr %0d exp cyc %0d addr 2", i, iss_cyc[i] - s, iss_addr[i], e_iss[i]);
            end
        end
        for (int i = 0; i < 4 && i < vld_cyc.size(); i++) begin
            checks++;
            if (vld_cyc[i] != s + e_vld[i] || vld_data[i] != e_dat[i]) begin
                errors++;
                $display("FAIL 1d_word[%0d]: cyc %0d data %h exp cyc %0d data %h", i, vld_cyc[i] - s, vld_data[i], e_vld[i], e_dat[i]);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 7) begin
            errors++;
            $display("FAIL 1d_done: pulses %0d exp 1 at rel cycle 7", done_cyc.size());
        end
    endtask

    task automatic test_2d();
        int s;
        int e_iss[6]  = '{1, 3, 5, 11, 13, 15};
        int e_addr[6] = '{0, 1, 2, 8, 9, 10};
        int e_vld[6]  = '{4, 6, 8, 14, 16, 18};
        int e_dat[6]  = '{32'h00, 32'h10, 32'h20, 32'h80, 32'h90, 32'hA0};
        clear_logs();
        cfg_1d('0, 3, 8, 2);
        cfg_dim = 4'd2;
        cfg_extent[1] = 16'd2; cfg_data_stride[1] = 19'd64; cfg_cycle_stride[1] = 16'd10;
        pulse_start(s);
        run_cycles(30);
        checks++;
        if (iss_cyc.size() != 6 || vld_cyc.size() != 6) begin
            errors++;
            $display("FAIL 2d_count: issues %0d valids %0d exp 6 6", iss_cyc.size(), vld_cyc.size());
        end
        for (int i = 0; i < 6 && i < iss_cyc.size(); i++) begin
            checks++;
            if (iss_cyc[i] != s + e_iss[i] || iss_addr[i] != e_addr[i]) begin
                errors++;
                $display("FAIL 2d_issue[%0d]: cyc %0d addr %0d exp cyc %0d addr %0d", i, iss_cyc[i] - s, iss_addr[i], e_iss[i], e_addr[i]);
            end
        end
        for (int i = 0; i < 6 && i < vld_cyc.size(); i++) begin
            checks++;
            if (vld_cyc[i] != s + e_vld[i] || vld_data[i] != e_dat[i]) begin
                errors++;
                $display("FAIL 2d_word[%0d]: cyc %0d data %h exp cyc %0d data %h", i, vld_cyc[i] - s, vld_data[i], e_vld[i], e_dat[i]);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 18) begin
            errors++;
            $display("FAIL 2d_done: pulses %0d exp 1 at rel cycle 18", done_cyc.size());
        end
    endtask

    // Zero cycle stride plus an outer level with extent 0 (behaves as 1).
    task automatic test_back_to_back();
        int s;
        int e_addr[5] = '{0, 0, 0, 0, 1};
        int e_dat[5]  = '{32'h00, 32'h01, 32'h02, 32'h03, 32'h10};
        clear_logs();
        cfg_1d('0, 5, 2, 0);
        cfg_dim = 4'd2;
        cfg_extent[1] = 16'd0; cfg_data_stride[1] = 19'h400; cfg_cycle_stride[1] = 16'd100;
        pulse_start(s);
        run_cycles(20);
        checks++;
        if (iss_cyc.size() != 5 || vld_cyc.size() != 5) begin
            errors++;
            $display("FAIL b2b_count: issues %0d valids %0d exp 5 5", iss_cyc.size(), vld_cyc.size());
        end
        for (int i = 0; i < 5 && i < iss_cyc.size(); i++) begin
            checks++;
            if (iss_cyc[i] != s + 1 + i || iss_addr[i] != e_addr[i]) begin
                errors++;
                $display("FAIL b2b_issue[%0d]: cyc %0d addr %0d exp cyc %0d addr %0d", i, iss_cyc[i] - s, iss_addr[i], 1 + i, e_addr[i]);
            end
        end
        for (int i = 0; i < 5 && i < vld_cyc.size(); i++) begin
            checks++;
            if (vld_cyc[i] != s + 4 + i || vld_data[i] != e_dat[i]) begin
                errors++;
                $display("FAIL b2b_word[%0d]: cyc %0d data %h exp cyc %0d data %h", i, vld_cyc[i] - s, vld_data[i], 4 + i, e_dat[i]);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 8) begin
            errors++;
            $display("FAIL b2b_done: pulses %0d exp 1 at rel cycle 8", done_cyc.size());
        end
    endtask

    task automatic test_stall();
        int s;
        int e_iss[6] = '{1, 2, 6, 7, 8, 9};
        int e_vld[6] = '{4, 5, 9, 10, 11, 12};
        clear_logs();
        cfg_1d('0, 6, 8, 1);
        pulse_start(s);
        run_cycles(2);
        stall = 1'b1;
        run_cycles(3);
        stall = 1'b0;
        run_cycles(15);
        checks++;
        if (iss_cyc.size() != 6 || vld_cyc.size() != 6) begin
            errors++;
            $display("FAIL stall_count: issues %0d valids %0d exp 6 6", iss_cyc.size(), vld_cyc.size());
        end
        for (int i = 0; i < 6 && i < iss_cyc.size(); i++) begin
            checks++;
            if (iss_cyc[i] != s + e_iss[i] || iss_addr[i] != i) begin
                errors++;
                $display("FAIL stall_issue[%0d]: cyc %0d addr %0d exp cyc %0d addr %0d", i, iss_cyc[i] - s, iss_addr[i], e_iss[i], i);
            end
        end
        for (int i = 0; i < 6 && i < vld_cyc.size(); i++) begin
            checks++;
            if (vld_cyc[i] != s + e_vld[i] || vld_data[i] != (i << 4)) begin
                errors++;
                $display("FAIL stall_word[%0d]: cyc %0d data %h exp cyc %0d data %h", i, vld_cyc[i] - s, vld_data[i], e_vld[i], i << 4);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 12) begin
            errors++;
            $display("FAIL stall_done: pulses %0d exp 1 at rel cycle 12", done_cyc.size());
        end
    endtask

    task automatic test_flush();
        int s;
        clear_logs();
        cfg_1d('0, 10, 8, 1);
        pulse_start(s);
        run_cycles(1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b exp 1", busy); end
        run_cycles(1);
        flush = 1'b1;
        run_cycles(1);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || io1_g2io !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: busy %b io1 %b exp 0 0", busy, io1_g2io);
        end
        run_cycles(20);
        checks++;
        if (vld_cyc.size() != 0 || done_cyc.size() != 0) begin
            errors++;
            $display("FAIL flush_quiet: valids %0d dones %0d exp 0 0", vld_cyc.size(), done_cyc.size());
        end
        // a fresh stream after the flush
        clear_logs();
        cfg_1d(19'h08, 2, 2, 1);
        pulse_start(s);
        run_cycles(12);
        checks++;
        if (vld_cyc.size() != 2 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL flush_restart_count: valids %0d dones %0d exp 2 1", vld_cyc.size(), done_cyc.size());
        end else begin
            checks++;
            if (vld_cyc[0] != s + 4 || vld_data[0] != 32'h10 || vld_data[1] != 32'h11 || done_cyc[0] != s + 5) begin
                errors++;
                $display("FAIL flush_restart_words: cyc %0d data %h %h done %0d exp 4 10 11 5",
                         vld_cyc[0] - s, vld_data[0], vld_data[1], done_cyc[0] - s);
            end
        end
    endtask

    task automatic test_dim0();
        int s;
        clear_logs();
        cfg_1d('0, 4, 2, 1);
        cfg_dim = 4'd0;
        pulse_start(s);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL dim0_busy: got %b exp 0", busy); end
        run_cycles(8);
        checks++;
        if (iss_cyc.size() != 0 || vld_cyc.size() != 0) begin
            errors++;
            $display("FAIL dim0_reads: issues %0d valids %0d exp 0 0", iss_cyc.size(), vld_cyc.size());
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 1) begin
            errors++;
            $display("FAIL dim0_done: pulses %0d exp 1 at rel cycle 1", done_cyc.size());
        end
    endtask

    task automatic test_async_reset();
        int s;
        clear_logs();
        cfg_1d('0, 10, 8, 1);
        pulse_start(s);
        run_cycles(5);
        checks++;
        if (io1_g2io !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: io1 %b busy %b exp 1 1", io1_g2io, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({io1_g2io, io16_g2io, mem_rd_en, mem_rd_addr, busy, done} !== '0) begin
            errors++;
            $display("FAIL rst_async: io1=%b io16=%h en=%b addr=%h busy=%b done=%b exp all 0",
                     io1_g2io, io16_g2io, mem_rd_en, mem_rd_addr, busy, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_cycles(15);
        checks++;
        if (done_cyc.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: dones %0d busy %b exp 0 0", done_cyc.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_1d();
        test_2d();
        test_back_to_back();
        test_stall();
        test_flush();
        test_dim0();
        test_async_reset();
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL idle_data_zero: nonzero io16 without valid %0d times exp 0", idle_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
